hog_feature_reader: RTL

- Read-back engine for the HOG feature map that the HOG pipeline writes into the four result BRAM banks (bank k holds one QN-bit feature lane per address).
- After a start pulse, it sweeps the bank addresses in lock-step through the banks' B ports and packs the four lanes into one beat.
- Beats stream out on an AXI-Stream master toward the DMA/correlation-filter stage.
- Full backpressure support via a credit-controlled output FIFO that absorbs BRAM read latency.

---
 rtl/hog_feature_reader_if.sv | 24 ++
 rtl/hog_feature_reader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hog_feature_reader_if.sv
// AXI-Stream style bus carrying packed HOG feature beats.
// Ports: tdata/tvalid/tlast from master, tready from slave.
interface hog_feature_reader_if #(
    parameter int DW = 40
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/hog_feature_reader.sv
// Sweeps the four HOG result BRAM banks and streams packed beats.
// Ports: aclk/arest, start/busy/done, bank B-port addr/enb/dout, m_axis.
module hog_feature_reader #(
    parameter int RAM_AW        = 17,
    parameter int QN            = 10,
    parameter int FEATURE_DEPTH = 7936,
    parameter int RD_LAT        = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic              aclk,
    input  logic              arest,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [RAM_AW-1:0] res_addrb_0,
    output logic [RAM_AW-1:0] res_addrb_1,
    output logic [RAM_AW-1:0] res_addrb_2,
    output logic [RAM_AW-1:0] res_addrb_3,
    output logic              enb_0,
    output logic              enb_1,
    output logic              enb_2,
    output logic              enb_3,
    input  logic [QN-1:0]     res_doutb_0,
    input  logic [QN-1:0]     res_doutb_1,
    input  logic [QN-1:0]     res_doutb_2,
    input  logic [QN-1:0]     res_doutb_3,
    hog_feature_reader_if.master m_axis
);
    localparam int DW = 4 * QN;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(RD_LAT + 1);

    localparam logic [RAM_AW-1:0] LAST_ADDR = RAM_AW'(FEATURE_DEPTH - 1);
    localparam logic [PW-1:0]     PTR_MAX   = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]       DEPTH_C   = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [RAM_AW-1:0] addr_q;
    logic [RD_LAT-1:0] vld_sr;
    logic [RD_LAT-1:0] last_sr;
    logic [IW-1:0]     inflight;
    logic              done_q;

    logic [DW-1:0] mem      [FIFO_DEPTH];
    logic          mem_last [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic credit_ok;
    logic start_ok;
    logic issue;
    logic push;
    logic pop;
    logic hs_last;
    logic [DW-1:0] beat_in;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PW'(1);
    endfunction

    // Reads still travelling through the BRAM pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + IW'(vld_sr[i]);
        end
    end

    // Every in-flight read owns a FIFO slot, so a push can never overflow.
    assign credit_ok = (({1'b0, count} + (CW + 1)'(inflight)) < DEPTH_C);

    // done_q blocks a start landing on the done cycle.
    assign start_ok = start && (state_q == S_IDLE) && !done_q;
    assign issue    = (state_q == S_READ) && credit_ok;
    assign push     = vld_sr[RD_LAT-1];
    assign pop      = m_axis.tvalid && m_axis.tready;
    assign hs_last  = pop && m_axis.tlast;
    assign beat_in  = {res_doutb_3, res_doutb_2, res_doutb_1, res_doutb_0};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_READ;
            end
            S_READ: begin
                if (issue && (addr_q == LAST_ADDR)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (hs_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge arest) begin
        if (arest) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            vld_sr  <= '0;
            last_sr <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= hs_last && (state_q == S_DRAIN);
            if (start_ok) begin
                addr_q <= '0;
            end else if (issue && (addr_q != LAST_ADDR)) begin
                addr_q <= addr_q + RAM_AW'(1);
            end
            vld_sr[0]  <= issue;
            last_sr[0] <= issue && (addr_q == LAST_ADDR);
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    always_ff @(posedge aclk or posedge arest) begin
        if (arest) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i]      <= '0;
                mem_last[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr]      <= beat_in;
                mem_last[wr_ptr] <= last_sr[RD_LAT-1];
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Head is masked while empty so stale entries never leak out.
    assign m_axis.tvalid = (count != '0);
    assign m_axis.tdata  = m_axis.tvalid ? mem[rd_ptr] : '0;
    assign m_axis.tlast  = m_axis.tvalid && mem_last[rd_ptr];

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

    assign enb_0 = issue;
    assign enb_1 = issue;
    assign enb_2 = issue;
    assign enb_3 = issue;

    assign res_addrb_0 = addr_q;
    assign res_addrb_1 = addr_q;
    assign res_addrb_2 = addr_q;
    assign res_addrb_3 = addr_q;
endmodule
